// File: rtl/nco_hop_sequencer.sv
// nco_hop_sequencer
//   Symbol-driven frequency-hop / FSK controller for the transmitter NCO.
//   Each accepted symbol is mapped through a programmable step table. The
//   step is held for a programmable number of cycles. Back-to-back symbols
//   keep the NCO phase running, and the NCO is parked on IDLE_STEP between
//   bursts.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   cfg_we       step-table write strobe
//   cfg_addr     step-table entry index
//   cfg_data     frequency step to store
//   dur_we       duration register write strobe
//   dur_data     cycles per symbol (0 is stored as 1)
//   sym_valid    symbol available
//   sym_data     symbol value
//   sym_ready    sequencer accepts a symbol this cycle
//   o_freq_step  frequency step to the NCO
//   o_nco_en     NCO accumulate enable
//   o_phase_clr  one-cycle NCO phase-accumulator clear
//   o_busy       burst in progress
//   o_done       one-cycle pulse at the end of a burst
module nco_hop_sequencer #(
  parameter int unsigned STEP_W = 10,
  parameter int unsigned SYM_W = 2,
  parameter int unsigned DUR_W = 16,
  parameter logic [STEP_W-1:0] IDLE_STEP = {STEP_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [SYM_W-1:0]  cfg_addr,
  input  logic [STEP_W-1:0] cfg_data,
  input  logic              dur_we,
  input  logic [DUR_W-1:0]  dur_data,
  input  logic              sym_valid,
  input  logic [SYM_W-1:0]  sym_data,
  output logic              sym_ready,
  output logic [STEP_W-1:0] o_freq_step,
  output logic              o_nco_en,
  output logic              o_phase_clr,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned DEPTH = 2 ** SYM_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A zero duration would make a symbol last no time at all, so it is
  // promoted to the shortest meaningful duration of one cycle.
  function automatic logic [DUR_W-1:0] clamp_dur(input logic [DUR_W-1:0] d);
    clamp_dur = (d == {DUR_W{1'b0}}) ? {{(DUR_W-1){1'b0}}, 1'b1} : d;
  endfunction

  logic [STEP_W-1:0] table_r [DEPTH];
  logic [DUR_W-1:0]  dur_r;

  state_t            state_r;
  state_t            state_s;
  logic [DUR_W-1:0]  cnt_r;
  logic [DUR_W-1:0]  cnt_s;
  logic [STEP_W-1:0] step_r;
  logic [STEP_W-1:0] step_s;
  logic              nco_en_r;
  logic              nco_en_s;
  logic              phase_clr_r;
  logic              phase_clr_s;
  logic              busy_r;
  logic              busy_s;
  logic              done_r;
  logic              done_s;
  logic              ready_s;
  logic              xfer_s;
  logic [STEP_W-1:0] lookup_s;
  logic [DUR_W-1:0]  reload_s;

  // Old table contents are read here; a same-cycle write lands only at the edge.
  assign lookup_s = table_r[sym_data];
  assign reload_s = dur_r - {{(DUR_W-1){1'b0}}, 1'b1};
  assign xfer_s   = sym_valid & ready_s;

  // Configuration registers: step table and symbol duration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= {STEP_W{1'b0}};
      end
      dur_r <= {{(DUR_W-1){1'b0}}, 1'b1};
    end else begin
      if (cfg_we) begin
        table_r[cfg_addr] <= cfg_data;
      end
      if (dur_we) begin
        dur_r <= clamp_dur(dur_data);
      end
    end
  end

  // Ready is open in IDLE and on the final cycle of the current symbol only.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ST_IDLE: ready_s = 1'b1;
      ST_RUN:  ready_s = (cnt_r == {DUR_W{1'b0}});
      default: ready_s = 1'b0;
    endcase
  end

  // Next-state and next-output logic for the hop sequencer.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    step_s      = step_r;
    nco_en_s    = nco_en_r;
    busy_s      = busy_r;
    phase_clr_s = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          // A new burst starts from a cleared phase accumulator.
          state_s     = ST_RUN;
          cnt_s       = reload_s;
          step_s      = lookup_s;
          nco_en_s    = 1'b1;
          busy_s      = 1'b1;
          phase_clr_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
          cnt_s    = {DUR_W{1'b0}};
          step_s   = IDLE_STEP;
          nco_en_s = 1'b0;
          busy_s   = 1'b0;
        end
      end
      ST_RUN: begin
        if (cnt_r != {DUR_W{1'b0}}) begin
          cnt_s = cnt_r - {{(DUR_W-1){1'b0}}, 1'b1};
        end else if (xfer_s) begin
          // A chained symbol keeps the phase running, so no clear is issued.
          state_s = ST_RUN;
          cnt_s   = reload_s;
          step_s  = lookup_s;
        end else begin
          state_s  = ST_IDLE;
          step_s   = IDLE_STEP;
          nco_en_s = 1'b0;
          busy_s   = 1'b0;
          done_s   = 1'b1;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        cnt_s    = {DUR_W{1'b0}};
        step_s   = IDLE_STEP;
        nco_en_s = 1'b0;
        busy_s   = 1'b0;
      end
    endcase
  end

  // State, counter and registered NCO-facing outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {DUR_W{1'b0}};
      step_r      <= IDLE_STEP;
      nco_en_r    <= 1'b0;
      phase_clr_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      step_r      <= step_s;
      nco_en_r    <= nco_en_s;
      phase_clr_r <= phase_clr_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign sym_ready   = ready_s;
  assign o_freq_step = step_r;
  assign o_nco_en    = nco_en_r;
  assign o_phase_clr = phase_clr_r;
  assign o_busy      = busy_r;
  assign o_done      = done_r;

endmodule
